i2cm_e2prom_reader: RTL and testbench

- I2C master that boot-loads configuration bytes from the on-board E2PROM slave. The slave answers at device bytes 8'ha0 and 8'ha2 and holds a 512x8 ROM.
- Sits directly upstream of that slave on scl/sda and streams the bytes it reads to the MCU load logic.
- Performs a random-address sequential read:
  - START, device-write byte, word address,
  - repeated START, device-read byte,
  - N data bytes, STOP.

---
 rtl/i2cm_e2prom_reader.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2cm_e2prom_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cm_e2prom_reader.sv
// I2C master performing a random-address sequential read from the boot E2PROM
// and streaming each received byte to the MCU load logic.
//
// state  | meaning
// IDLE   | bus released, waiting for start
// START  | SDA falls while SCL high, then SCL falls
// DEVW   | device byte with write bit
// ACK1   | slave ACK of device-write byte
// WADDR  | low 8 bits of word address
// ACK2   | slave ACK of word address
// RSTART | repeated START
// DEVR   | device byte with read bit
// ACK3   | slave ACK of device-read byte
// RDATA  | 8 data bits shifted in, MSB first
// MACK   | master ACK (more bytes) or NACK (last byte)
// STOP   | SDA low, SCL rises, SDA released
// DONE   | one-cycle done pulse
module i2cm_e2prom_reader #(
    parameter int unsigned CLK_DIV  = 8,
    parameter logic [6:0]  DEV_ADDR = 7'h50
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [8:0] rd_addr,
    input  logic [8:0] rd_len,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_ACK1, S_WADDR, S_ACK2, S_RSTART,
        S_DEVR, S_ACK3, S_RDATA, S_MACK, S_STOP, S_DONE
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [8:0] addr_q, addr_d;
    logic [8:0] left_q, left_d;
    logic       nack_seen_q, nack_seen_d;
    logic       nack_err_q, nack_err_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       oe_q, oe_d;

    logic       phase_end, bit_end, sample, accept;
    logic [7:0] dev_w, dev_r;

    // Line levels for a given state/phase, returned as {scl, oe}.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph,
                                             input logic tx_bit, input logic last);
        logic       bit_scl;
        logic [1:0] r;
        bit_scl = (ph == 2'd1) || (ph == 2'd2);
        case (st)
            S_START:                        r = {1'b1, ph != 2'd0};
            S_RSTART:                       r = {ph != 2'd0, ph == 2'd2};
            S_STOP:                         r = {ph != 2'd0, ph != 2'd2};
            S_DEVW, S_WADDR, S_DEVR:        r = {bit_scl, ~tx_bit};
            S_ACK1, S_ACK2, S_ACK3, S_RDATA: r = {bit_scl, 1'b0};
            S_MACK:                         r = {bit_scl, ~last};
            default:                        r = 2'b10;
        endcase
        return r;
    endfunction

    assign dev_w     = {DEV_ADDR[6:1], addr_q[8], 1'b0};
    assign dev_r     = dev_w | 8'h01;
    assign phase_end = (cnt_q == 8'd0);
    assign bit_end   = phase_end && (ph_q == 2'd3);
    assign sample    = phase_end && (ph_q == 2'd1);
    assign accept    = (state_q == S_IDLE) && start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        left_d      = left_q;
        nack_seen_d = nack_seen_q;
        nack_err_d  = nack_err_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (phase_end) begin
                cnt_d = DIV_M1;
                ph_d  = ph_q + 2'd1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d      = rd_addr;
                    left_d      = rd_len;
                    nack_seen_d = 1'b0;
                    nack_err_d  = 1'b0;
                    cnt_d       = DIV_M1;
                    ph_d        = 2'd0;
                    state_d     = (rd_len == 9'd0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                if (phase_end && ph_q == 2'd1) begin
                    state_d = S_DEVW;
                    ph_d    = 2'd0;
                    sh_d    = dev_w;
                    bit_d   = 3'd0;
                end
            end
            S_DEVW, S_WADDR, S_DEVR: begin
                if (bit_end) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        case (state_q)
                            S_DEVW:  state_d = S_ACK1;
                            S_WADDR: state_d = S_ACK2;
                            default: state_d = S_ACK3;
                        endcase
                    end
                end
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                if (sample && sda_in) begin
                    nack_seen_d = 1'b1;
                end
                if (bit_end) begin
                    bit_d = 3'd0;
                    if (nack_seen_q) begin
                        state_d = S_STOP;
                    end else begin
                        case (state_q)
                            S_ACK1: begin
                                state_d = S_WADDR;
                                sh_d    = addr_q[7:0];
                            end
                            S_ACK2:  state_d = S_RSTART;
                            default: state_d = S_RDATA;
                        endcase
                    end
                end
            end
            S_RSTART: begin
                if (phase_end && ph_q == 2'd2) begin
                    state_d = S_DEVR;
                    ph_d    = 2'd0;
                    sh_d    = dev_r;
                    bit_d   = 3'd0;
                end
            end
            S_RDATA: begin
                if (sample) begin
                    sh_d = {sh_q[6:0], sda_in};
                    if (bit_q == 3'd7) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = {sh_q[6:0], sda_in};
                        left_d     = left_q - 9'd1;
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_MACK;
                    end
                end
            end
            S_MACK: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = (left_q != 9'd0) ? S_RDATA : S_STOP;
                end
            end
            S_STOP: begin
                if (phase_end && ph_q == 2'd2) begin
                    state_d    = S_DONE;
                    ph_d       = 2'd0;
                    nack_err_d = nack_seen_q;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A zero-length request still reports busy for its single done cycle.
        busy_d         = (state_d != S_IDLE && state_d != S_DONE) || (accept && rd_len == 9'd0);
        done_d         = (state_d == S_DONE);
        {scl_d, oe_d}  = bus_drive(state_d, ph_d, sh_d[7], left_d == 9'd0);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            ph_q        <= 2'd0;
            bit_q       <= 3'd0;
            sh_q        <= 8'h00;
            addr_q      <= 9'd0;
            left_q      <= 9'd0;
            nack_seen_q <= 1'b0;
            nack_err_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            scl_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            nack_seen_q <= nack_seen_d;
            nack_err_q  <= nack_err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            scl_q       <= scl_d;
            oe_q        <= oe_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_err_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign scl      = scl_q;
    assign sda_oe   = oe_q;
    assign sda_out  = 1'b0;

endmodule

// File: tb/tb_i2cm_e2prom_reader.sv
// Bench for i2cm_e2prom_reader: behavioural E2PROM slave on the bus, reference
// byte stream from ROM[i] = i[7:0] ^ 8'h5a, scoreboard checked on rd_valid/done.
module tb_i2cm_e2prom_reader;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       start_r;
    logic       sel;
    logic [8:0] rd_addr;
    logic [8:0] rd_len;

    always #5 sys_clk = ~sys_clk;

    logic       start0, busy0, done0, nack0, rvalid0, scl0, sdaout0, oe0;
    logic       start1, busy1, done1, nack1, rvalid1, scl1, sdaout1, oe1;
    logic [7:0] rdata0, rdata1;
    logic       sda_line, s_pull;

    assign start0   = start_r & ~sel;
    assign start1   = start_r & sel;
    assign sda_line = ~((sel ? oe1 : oe0) | s_pull);

    logic       busy_m, done_m, nack_m, rvalid_m, scl_m, oe_m;
    logic [7:0] rdata_m;
    assign busy_m   = sel ? busy1   : busy0;
    assign done_m   = sel ? done1   : done0;
    assign nack_m   = sel ? nack1   : nack0;
    assign rvalid_m = sel ? rvalid1 : rvalid0;
    assign scl_m    = sel ? scl1    : scl0;
    assign oe_m     = sel ? oe1     : oe0;
    assign rdata_m  = sel ? rdata1  : rdata0;

    i2cm_e2prom_reader #(.CLK_DIV(4), .DEV_ADDR(7'h50)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start0), .rd_addr(rd_addr),
        .rd_len(rd_len), .busy(busy0), .done(done0), .nack_err(nack0),
        .rd_data(rdata0), .rd_valid(rvalid0), .scl(scl0), .sda_in(sda_line),
        .sda_out(sdaout0), .sda_oe(oe0));

    // Second instance whose device bytes (a4/a6) the slave does not answer.
    i2cm_e2prom_reader #(.CLK_DIV(4), .DEV_ADDR(7'h52)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start1), .rd_addr(rd_addr),
        .rd_len(rd_len), .busy(busy1), .done(done1), .nack_err(nack1),
        .rd_data(rdata1), .rd_valid(rvalid1), .scl(scl1), .sda_in(sda_line),
        .sda_out(sdaout1), .sda_oe(oe1));

    int compared = 0;
    int mismatched = 0;

    logic [7:0] exp_data_q[$];
    logic [1:0] exp_done_q[$];
    logic [7:0] obs_q[$];

    function automatic logic [7:0] rom(input int a);
        logic [7:0] v;
        v = 8'(a % 256);
        return v ^ 8'h5a;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural E2PROM slave: answers device bytes a0..a3, 512-byte ROM.
    int         s_mode, s_rcnt, s_byte, s_starts, s_falls, s_macks, s_mnacks;
    logic [7:0] s_rx, s_tx;
    logic [8:0] s_ptr;
    logic       s_blk, s_rw, s_mack;

    initial begin
        logic scl_n, sda_n, p_scl, p_sda;
        s_pull = 1'b0; s_mode = 0; s_rcnt = 0; s_byte = 0;
        s_starts = 0; s_falls = 0; s_macks = 0; s_mnacks = 0;
        s_rx = 8'h00; s_tx = 8'h00; s_ptr = 9'd0; s_blk = 1'b0; s_rw = 1'b0; s_mack = 1'b0;
        p_scl = 1'b1; p_sda = 1'b1;
        forever begin
            @(negedge sys_clk);
            scl_n = scl_m;
            sda_n = sda_line;
            if (sys_rst) begin
                s_mode = 0; s_pull = 1'b0; s_rcnt = 0; p_scl = 1'b1; p_sda = 1'b1;
            end else begin
                if (p_scl && scl_n && p_sda && !sda_n) begin
                    s_mode = 1; s_rcnt = 0; s_byte = 0; s_starts++;
                end else if (p_scl && scl_n && !p_sda && sda_n) begin
                    s_mode = 0; s_pull = 1'b0;
                end else if (!p_scl && scl_n) begin
                    if (s_mode == 1) begin
                        if (s_rcnt < 8) s_rx = {s_rx[6:0], sda_n};
                        s_rcnt++;
                    end else if (s_mode == 2) begin
                        s_rcnt++;
                        if (s_rcnt == 9) begin
                            s_mack = !sda_n;
                            if (s_mack) s_macks++; else s_mnacks++;
                        end
                    end
                end else if (p_scl && !scl_n) begin
                    s_falls++;
                    if (s_mode == 1) begin
                        if (s_rcnt == 8) begin
                            if (s_byte < 2) obs_q.push_back(s_rx);
                            if (s_byte == 0) begin
                                if (s_rx[7:2] == 6'b101000) begin
                                    s_pull = 1'b1; s_blk = s_rx[1]; s_rw = s_rx[0];
                                end else begin
                                    s_mode = 0; s_pull = 1'b0;
                                end
                            end else begin
                                if (s_byte == 1) s_ptr = {s_blk, s_rx};
                                s_pull = 1'b1;
                            end
                        end else if (s_rcnt == 9) begin
                            s_pull = 1'b0; s_rcnt = 0;
                            if (s_byte == 0 && s_rw) begin
                                s_mode = 2; s_tx = rom(int'(s_ptr)); s_ptr = s_ptr + 9'd1;
                                s_pull = ~s_tx[7];
                            end
                            s_byte++;
                        end
                    end else if (s_mode == 2) begin
                        if (s_rcnt >= 1 && s_rcnt <= 7) begin
                            s_pull = ~s_tx[7 - s_rcnt];
                        end else if (s_rcnt == 8) begin
                            s_pull = 1'b0;
                        end else if (s_rcnt == 9) begin
                            s_rcnt = 0;
                            if (s_mack) begin
                                s_tx = rom(int'(s_ptr)); s_ptr = s_ptr + 9'd1;
                                s_pull = ~s_tx[7];
                            end else begin
                                s_mode = 0; s_pull = 1'b0;
                            end
                        end
                    end
                end
                p_scl = scl_n;
                p_sda = sda_n;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                if (rvalid_m) begin
                    if (exp_data_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL rd_valid_unexpected: got data %0h expected none", rdata_m);
                    end else begin
                        chk("rd_data", int'(rdata_m), int'(exp_data_q.pop_front()));
                    end
                end
                if (done_m) begin
                    if (exp_done_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL done_unexpected: got done=1 expected 0");
                    end else begin
                        e = exp_done_q.pop_front();
                        chk("nack_err", int'(nack_m), int'(e[1]));
                        chk("busy_at_done", int'(busy_m), int'(e[0]));
                    end
                end
            end
        end
    end

    task automatic run_txn(input logic s, input logic [8:0] a, input logic [8:0] l,
                           input logic exp_nack, input logic mid_start);
        logic [6:0] base;
        logic [7:0] devw;
        int         budget, n_start, n_fall, m_ack0, m_nack0;
        logic       got;
        sel  = s;
        base = s ? 7'h52 : 7'h50;
        devw = {base[6:1], a[8], 1'b0};
        obs_q.delete();
        n_start = s_starts; n_fall = s_falls; m_ack0 = s_macks; m_nack0 = s_mnacks;
        if (!exp_nack) begin
            for (int i = 0; i < int'(l); i++) exp_data_q.push_back(rom((int'(a) + i) % 512));
        end
        exp_done_q.push_back({exp_nack, l == 9'd0});
        @(negedge sys_clk);
        start_r = 1'b1; rd_addr = a; rd_len = l;
        @(negedge sys_clk);
        start_r = 1'b0;
        if (l == 9'd0) begin
            chk("len0_done_next_cycle", int'(done_m), 1);
            chk("len0_busy", int'(busy_m), 1);
        end
        budget = (int'(l) + 4) * 9 * 16 + 200;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            if (done_m) begin
                got = 1'b1;
            end else begin
                if (mid_start && n == 2000) begin
                    start_r = 1'b1; rd_addr = 9'h155; rd_len = 9'd5;
                end
                @(negedge sys_clk);
                start_r = 1'b0;
            end
        end
        chk("done_seen", int'(got), 1);
        if (!got) exp_done_q.delete();
        repeat (3) @(negedge sys_clk);
        chk("bytes_outstanding", exp_data_q.size(), 0);
        exp_data_q.delete();
        chk("idle_scl", int'(scl_m), 1);
        chk("idle_sda_oe", int'(oe_m), 0);
        chk("idle_busy", int'(busy_m), 0);
        if (l == 9'd0) begin
            chk("len0_scl_falls", s_falls - n_fall, 0);
            chk("len0_starts", s_starts - n_start, 0);
        end else if (exp_nack) begin
            chk("nack_bytes_on_bus", obs_q.size(), 1);
            if (obs_q.size() > 0) chk("nack_devw", int'(obs_q[0]), int'(devw));
            chk("nack_starts", s_starts - n_start, 1);
        end else begin
            chk("bus_byte_count", obs_q.size(), 3);
            if (obs_q.size() == 3) begin
                chk("bus_devw", int'(obs_q[0]), int'(devw));
                chk("bus_waddr", int'(obs_q[1]), int'(a[7:0]));
                chk("bus_devr", int'(obs_q[2]), int'(devw | 8'h01));
            end
            chk("bus_starts", s_starts - n_start, 2);
            chk("master_acks", s_macks - m_ack0, int'(l) - 1);
            chk("master_nacks", s_mnacks - m_nack0, 1);
        end
    endtask

    initial begin
        logic [8:0] ra;
        logic [8:0] rl;
        logic       hit;
        sys_rst = 1'b1; start_r = 1'b0; sel = 1'b0; rd_addr = 9'd0; rd_len = 9'd0;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_nack_err", int'(nack0), 0);
        chk("rst_rd_data", int'(rdata0), 0);
        chk("rst_rd_valid", int'(rvalid0), 0);
        chk("rst_scl", int'(scl0), 1);
        chk("rst_sda_oe", int'(oe0), 0);
        chk("rst_sda_out", int'(sdaout0), 0);
        chk("rst_scl_b", int'(scl1), 1);
        chk("rst_sda_out_b", int'(sdaout1), 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        run_txn(1'b0, 9'h010, 9'd4, 1'b0, 1'b0);
        run_txn(1'b0, 9'h1ff, 9'd2, 1'b0, 1'b0);
        run_txn(1'b1, 9'h033, 9'd3, 1'b1, 1'b0);
        run_txn(1'b0, 9'h077, 9'd0, 1'b0, 1'b0);
        run_txn(1'b0, 9'h000, 9'd256, 1'b0, 1'b1);

        // Reset in the middle of a data byte, then a clean transaction.
        sel = 1'b0;
        for (int i = 0; i < 8; i++) exp_data_q.push_back(rom(16'h0a0 + i));
        exp_done_q.push_back(2'b00);
        @(negedge sys_clk);
        start_r = 1'b1; rd_addr = 9'h0a0; rd_len = 9'd8;
        @(negedge sys_clk);
        start_r = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            if (s_mode == 2 && s_rcnt == 4) hit = 1'b1;
            else @(negedge sys_clk);
        end
        chk("reached_rdata", int'(hit), 1);
        sys_rst = 1'b1;
        exp_data_q.delete();
        exp_done_q.delete();
        @(negedge sys_clk);
        chk("midrst_scl", int'(scl0), 1);
        chk("midrst_sda_oe", int'(oe0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        sys_rst = 1'b0;
        repeat (100) @(negedge sys_clk);
        run_txn(1'b0, 9'h0a0, 9'd3, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ra = 9'($urandom_range(0, 511));
            rl = 9'($urandom_range(1, 12));
            run_txn(1'b0, ra, rl, 1'b0, 1'b0);
        end
        run_txn(1'b1, 9'($urandom_range(0, 511)), 9'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
